// File: rtl/cla_pkg.sv
// cla_pkg: shared state encoding, default width and divide-by-zero quotient helper
// for the carry-lookahead sequential divider.
package cla_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_e;

    function automatic logic [31:0] all_ones(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : (32'h1 << w) - 32'h1;
    endfunction

endpackage

// File: rtl/cla_sub_w.sv
// cla_sub_w: W-bit carry-lookahead subtractor computing a + ~b + 1;
// borrow_n_o high means a >= b.
module cla_sub_w #(
    parameter int W = 9
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_n_o
);
    logic [W-1:0] g, p;
    logic [W:0]   c;
    logic         acc, cy;

    assign g = a_i & ~b_i;
    assign p = a_i ^ ~b_i;

    // Each carry is the flattened sum-of-products over all lower generates plus c_in=1.
    always_comb begin
        c   = '0;
        acc = 1'b0;
        cy  = 1'b0;
        c[0] = 1'b1;
        for (int i = 0; i < W; i++) begin
            acc = 1'b1;
            cy  = 1'b0;
            for (int j = i; j >= 0; j--) begin
                cy  = cy | (acc & g[j]);
                acc = acc & p[j];
            end
            c[i+1] = cy | acc;
        end
    end

    assign diff_o     = p ^ c[W-1:0];
    assign borrow_n_o = c[W];

endmodule

// File: rtl/cla_seq_div.sv
// cla_seq_div: iterative restoring divider, one quotient bit per cycle via cla_sub_w.
// Define CLA_SEQ_DIV_SIGNED_EN for two's complement operands (one extra fix-up cycle).
module cla_seq_div
    import cla_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d, q_q, q_d, dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
    logic             dz_q, dz_d, dzo_q, dzo_d, busy_q, busy_d, done_q, done_d;
    logic [WIDTH:0]   sh, diff;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             borrow_n, take, fin_go;

`ifdef CLA_SEQ_DIV_SIGNED_EN
    logic qneg_q, qneg_d, rneg_q, rneg_d, fix_q, fix_d;
    assign a_mag  = dividend[WIDTH-1] ? -dividend : dividend;
    assign b_mag  = divisor[WIDTH-1] ? -divisor : divisor;
    assign fin_go = fix_q;
`else
    assign a_mag  = dividend;
    assign b_mag  = divisor;
    assign fin_go = 1'b1;
`endif

    assign sh = {r_q, q_q[WIDTH-1]};

    cla_sub_w #(.W(WIDTH + 1)) u_sub (
        .a_i       (sh),
        .b_i       ({1'b0, dvs_q}),
        .diff_o    (diff),
        .borrow_n_o(borrow_n)
    );

    // An accepted trial always fits in WIDTH bits; the MSB term keeps that explicit.
    assign take = borrow_n & ~diff[WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        dzo_d   = dzo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef CLA_SEQ_DIV_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        fix_d   = fix_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && !done_q) begin
                    if (divisor == '0) begin
                        state_d = FIN;
                        q_d     = WIDTH'(all_ones(WIDTH));
                        r_d     = dividend;
                        dz_d    = 1'b1;
`ifdef CLA_SEQ_DIV_SIGNED_EN
                        fix_d   = 1'b1;
`endif
                    end else begin
                        state_d = CALC;
                        busy_d  = 1'b1;
                        dvs_d   = b_mag;
                        q_d     = a_mag;
                        r_d     = '0;
                        cnt_d   = CNT_W'(WIDTH);
                        dz_d    = 1'b0;
`ifdef CLA_SEQ_DIV_SIGNED_EN
                        qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        rneg_d  = dividend[WIDTH-1];
                        fix_d   = 1'b0;
`endif
                    end
                end
            end
            CALC: begin
                cnt_d   = cnt_q - CNT_W'(1);
                r_d     = take ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
                q_d     = {q_q[WIDTH-2:0], take};
                state_d = (cnt_q == CNT_W'(1)) ? FIN : CALC;
            end
            FIN: begin
                if (fin_go) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    quo_d   = q_q;
                    rem_d   = r_q;
                    dzo_d   = dz_q;
                end
`ifdef CLA_SEQ_DIV_SIGNED_EN
                else begin
                    fix_d = 1'b1;
                    q_d   = qneg_q ? -q_q : q_q;
                    r_d   = rneg_q ? -r_q : r_q;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            dzo_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            dzo_q   <= dzo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef CLA_SEQ_DIV_SIGNED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            fix_q  <= 1'b0;
        end else begin
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            fix_q  <= fix_d;
        end
    end
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign div_zero  = dzo_q;

endmodule

// File: tb/tb_cla_seq_div.sv
// tb_cla_seq_div: directed scoreboard bench for the unsigned WIDTH=8 build of cla_seq_div.
module tb_cla_seq_div;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } exp_t;

    logic       clk, rst_n, start;
    logic [7:0] dividend, divisor;
    logic       busy, done, div_zero;
    logic [7:0] quotient, remainder;

    exp_t sb[$];
    int   tests, fails, done_cnt, base;

    cla_seq_div #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.q  = (b == 8'd0) ? 8'hFF : a / b;
        e.r  = (b == 8'd0) ? a : a % b;
        e.dz = (b == 8'd0);
        sb.push_back(e);
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts posedges until done; first posedge after the start edge counts as 1.
    task automatic wait_check(input string tag, input int exp_lat);
        exp_t e;
        int   lat;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (done === 1'b1) break;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_q"}, quotient, e.q);
            chk({tag, "_r"}, remainder, e.r);
            chk({tag, "_dz"}, div_zero, e.dz);
        end
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, done, 0);
    endtask

    task automatic op(input string tag, input logic [7:0] a, input logic [7:0] b, input int lat);
        push(a, b);
        drive(a, b);
        wait_check(tag, lat);
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        done_cnt = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dz", div_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        op("d100_7", 8'd100, 8'd7, 9);
        op("d255_1", 8'd255, 8'd1, 9);
        op("d3_200", 8'd3, 8'd200, 9);
        op("d45_0", 8'd45, 8'd0, 1);
        op("d9_3", 8'd9, 8'd3, 9);
        op("d77_77", 8'd77, 8'd77, 9);

        // A second start during an active divide must be ignored.
        base = done_cnt;
        push(8'd200, 8'd9);
        drive(8'd200, 8'd9);
        repeat (2) @(negedge clk);
        chk("busy_mid", busy, 1);
        dividend = 8'd50;
        divisor  = 8'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_check("ign", 6);
        repeat (12) @(posedge clk);
        #1;
        chk("ign_one_done", done_cnt - base, 1);

        // Async reset in the middle of an operation aborts it.
        drive(8'd200, 8'd9);
        repeat (2) @(negedge clk);
        base  = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_q", quotient, 0);
        chk("abort_r", remainder, 0);
        chk("abort_dz", div_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - base, 0);

        op("d12_4", 8'd12, 8'd4, 9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
